div_tick_gen: RTL and testbench
===============================

# div_tick_gen

Parametrised four-channel timebase generator: derives per-channel one-cycle tick enables and square-wave outputs from the 50 MHz system clock. Each channel has a runtime-programmable divisor, glitch-free divisor update, and an optional cascade mode in which the channel counts ticks of the channel below it. It replaces fixed-ratio clock dividers in the clock design; downstream counters (seconds, scan, debounce) use `tick` as a clock enable on `clk_50mhz` instead of using derived clocks.

## Interface
- `CNT_W`, 26: counter and divisor width; must hold the largest divisor.
- `DIV0`, 50_000_000: reset divisor of channel 0 (1 Hz).
- `DIV1`, 500_000: reset divisor of channel 1 (100 Hz).
- `DIV2`, 50_000: reset divisor of channel 2 (1 kHz).
- `DIV3`, 50: reset divisor of channel 3 (1 MHz).

- `clk_50mhz` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ch_en` in 4: per-channel count enable.
- `casc` in 4: bit k=1 puts channel k in cascade mode (k≥1); bit 0 ignored.
- `sync` in 1: restart all channels phase-aligned.
- `div_wr` in 1: divisor write strobe.
- `div_sel` in 2: channel addressed by `div_wr`.
- `div_val` in CNT_W: new divisor.
- `tick` out 4: one-cycle enable pulse per channel period.
- `sq` out 4: square wave per channel.
- `div_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- Per channel k: counter `cnt[k]`, active divisor `D[k]`, pending divisor `P[k]` with valid flag `pv[k]`.
- Advance condition `adv[k]` = `ch_en[k]` and (`casc[k]`=0 or k=0 or `tick[k-1]`=1).
- On `adv[k]`: `cnt[k]` ← 0 if `cnt[k]`=D[k]−1, else `cnt[k]`+1. No advance: `cnt[k]` holds.
- `tick[k]` = `adv[k]` and `cnt[k]`=D[k]−1 (combinational from registered state and inputs; cascade ripples within one cycle, k=0→3).
- `sq[k]` registered; equals 1 iff `cnt[k]` < D[k]>>1 after the same edge. D even → exact 50% duty; D odd → high (D−1)/2 of D periods; D=1 → `sq` constant 0, `tick` equals `adv`.
- Divisor write: `div_wr`=1 with `div_val`=0 → ignored, `div_err`=1 next cycle. Otherwise `P[div_sel]`←`div_val`, `pv`←1 (a second write before application overwrites P).
- Pending application: D[k]←P[k], `pv[k]`←0, on the edge where channel k wraps (`tick[k]`=1), or immediately if `ch_en[k]`=0, or on `sync`. Applying on wrap means the new period starts at `cnt`=0; no truncated or stretched period is ever emitted.
- Write and wrap on the same edge for same channel: the wrap applies the old P (if valid); the new write becomes pending.
- `sync`=1: all `cnt`←0, all valid pending applied, `tick` forced 0 that cycle. `sync` has priority over advance and over wrap-time application; a simultaneous `div_wr` is accepted and applied by the sync.
- `rst`: `cnt`=0, D[k]=DIVk, `pv`=0, `sq`=0, `div_err`=0; `tick`=0 while `rst`=1. Reset mid-period discards the period and any pending write.

## Timing
- First `tick[k]` at the D[k]-th enabled cycle after reset release/sync (cnt 0..D−1).
- Period of `tick[k]` = D[k] advances; in cascade, D[k] × period of channel k−1.
- `div_err` latency 1 cycle. Write-to-effect: next wrap of channel k, or 1 cycle if disabled or synced.
- Disabling a channel freezes `cnt`, `sq`; re-enabling resumes mid-period.

## Test plan
- Reset defaults, DIV3=50: after `rst` release with `ch_en`=4'b1000, `tick[3]` every 50 cycles, first at cycle 50; `sq[3]` high 25, low 25.
- Set D0=4, D1=3 cascade (`casc[1]`=1), both enabled: `tick[0]` every 4 cycles, `tick[1]` every 12, coincident with every third `tick[0]`.
- Write `div_val`=6 to channel 2 (D2=10) at cnt=3: current period ends at 10 cycles, then periods of 6; no intermediate length.
- Write `div_val`=0: `div_err` pulses 1 cycle later, D unchanged.
- Channels with D=5 and D=7 running out of phase, assert `sync` 1 cycle: next cycle all cnt=0, no tick that cycle; next ticks 5 and 7 cycles later.
- Odd divisor D=5: `sq` pattern 1,1,0,0,0 repeating; D=1: `tick` high every enabled cycle, `sq`=0.

Source files
------------

// File: rtl/div_tick_gen_if.sv
// Divisor programming bus for div_tick_gen.
// Master writes a divisor; slave flags rejected writes.
interface div_tick_gen_if #(
    parameter int CNT_W = 26
);
    logic             div_wr;
    logic [1:0]       div_sel;
    logic [CNT_W-1:0] div_val;
    logic             div_err;

    modport master (
        output div_wr,
        output div_sel,
        output div_val,
        input  div_err
    );

    modport slave (
        input  div_wr,
        input  div_sel,
        input  div_val,
        output div_err
    );
endinterface

// File: rtl/div_tick_gen.sv
// Four-channel timebase: per-channel tick enables and square waves
// with glitch-free divisor update and optional cascade.
module div_tick_gen #(
    parameter int CNT_W = 26,
    parameter int DIV0  = 50_000_000,
    parameter int DIV1  = 500_000,
    parameter int DIV2  = 50_000,
    parameter int DIV3  = 50
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    input  logic [3:0]    ch_en,
    input  logic [3:0]    casc,
    input  logic          sync,
    div_tick_gen_if.slave div_bus,
    output logic [3:0]    tick,
    output logic [3:0]    sq
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t ONE = cnt_t'(1);
    localparam cnt_t DIV_RST [4] = '{
        cnt_t'(DIV0), cnt_t'(DIV1),
        cnt_t'(DIV2), cnt_t'(DIV3)
    };

    cnt_t       cnt_q [4];
    cnt_t       d_q   [4];
    cnt_t       p_q   [4];
    logic [3:0] pv_q;

    cnt_t       cnt_n [4];
    cnt_t       d_n   [4];
    cnt_t       p_n   [4];
    logic [3:0] pv_n;
    logic [3:0] sq_n;

    logic wr_ok;
    logic prev;
    logic wrap;
    logic adv;
    logic wr_k;
    logic apply;

    always_comb begin
        wr_ok = div_bus.div_wr && (div_bus.div_val != '0);
        prev  = 1'b0;
        wrap  = 1'b0;
        adv   = 1'b0;
        wr_k  = 1'b0;
        apply = 1'b0;
        tick  = '0;
        pv_n  = pv_q;
        sq_n  = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_n[k] = cnt_q[k];
            d_n[k]   = d_q[k];
            p_n[k]   = p_q[k];
            wrap = (cnt_q[k] == d_q[k] - ONE);
            // Cascade ripples through prev within one cycle.
            adv  = ch_en[k] && (k == 0 || !casc[k] || prev);
            prev = adv && wrap && !sync && !rst;
            tick[k] = prev;
            wr_k = wr_ok && (div_bus.div_sel == 2'(k));
            if (sync) begin
                cnt_n[k] = '0;
                if (wr_k) begin
                    d_n[k] = div_bus.div_val;
                    p_n[k] = div_bus.div_val;
                end else if (pv_q[k]) begin
                    d_n[k] = p_q[k];
                end
                pv_n[k] = 1'b0;
            end else begin
                if (adv) begin
                    cnt_n[k] = wrap ? '0 : cnt_q[k] + ONE;
                end
                // Apply only at a period boundary or while idle.
                apply = pv_q[k] && (prev || !ch_en[k]);
                if (apply) begin
                    d_n[k]  = p_q[k];
                    pv_n[k] = 1'b0;
                end
                if (wr_k) begin
                    p_n[k]  = div_bus.div_val;
                    pv_n[k] = 1'b1;
                end
            end
            sq_n[k] = (cnt_n[k] < (d_n[k] >> 1));
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
                d_q[k]   <= DIV_RST[k];
                p_q[k]   <= '0;
            end
            pv_q           <= '0;
            sq             <= '0;
            div_bus.div_err <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_n[k];
                d_q[k]   <= d_n[k];
                p_q[k]   <= p_n[k];
            end
            pv_q           <= pv_n;
            sq             <= sq_n;
            div_bus.div_err <= div_bus.div_wr &&
                               (div_bus.div_val == '0);
        end
    end

endmodule

// File: tb/tb_div_tick_gen.sv
// Directed self-checking bench for div_tick_gen.
// Each task drives one scenario and checks inline.
module tb_div_tick_gen;

    localparam int CNT_W = 26;

    logic       clk;
    logic       rst;
    logic [3:0] ch_en;
    logic [3:0] casc;
    logic       sync;
    logic [3:0] tick;
    logic [3:0] sq;

    int checks;
    int passed;

    div_tick_gen_if #(.CNT_W(CNT_W)) bus ();

    div_tick_gen #(.CNT_W(CNT_W)) dut (
        .clk_50mhz (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .casc      (casc),
        .sync      (sync),
        .div_bus   (bus.slave),
        .tick      (tick),
        .sq        (sq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int v);
        bus.div_wr  = 1'b1;
        bus.div_sel = 2'(ch);
        bus.div_val = CNT_W'(v);
        cyc();
        bus.div_wr  = 1'b0;
    endtask

    task automatic sync_pulse(input logic [3:0] en);
        sync  = 1'b1;
        ch_en = en;
        cyc();
        sync  = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] et;
        logic       es;
        rst   = 1'b1;
        ch_en = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (tick !== 4'b0 || sq !== 4'b0 || bus.div_err !== 1'b0)
                $display("FAIL reset: tick=%b sq=%b err=%b want 0",
                         tick, sq, bus.div_err);
            else passed++;
            cyc();
        end
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            #1;
            et = (n % 50 == 0) ? 4'b1000 : 4'b0000;
            es = (n == 1) ? 1'b0 : (((n - 1) % 50) < 25);
            checks++;
            if (tick !== et)
                $display("FAIL div3_tick n=%0d: got %b want %b", n, tick, et);
            else passed++;
            checks++;
            if (sq[3] !== es)
                $display("FAIL div3_sq n=%0d: got %b want %b", n, sq[3], es);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_cascade();
        logic [3:0] et;
        ch_en = 4'b0;
        casc  = 4'b0;
        set_div(0, 4);
        set_div(1, 3);
        sync_pulse(4'b0);
        casc  = 4'b0010;
        ch_en = 4'b0011;
        for (int n = 1; n <= 24; n++) begin
            #1;
            et = {2'b00, n % 12 == 0, n % 4 == 0};
            checks++;
            if (tick !== et)
                $display("FAIL cascade n=%0d: got %b want %b", n, tick, et);
            else passed++;
            cyc();
        end
        casc = 4'b0;
    endtask

    task automatic test_div_update();
        logic [3:0] et;
        ch_en = 4'b0;
        set_div(2, 10);
        sync_pulse(4'b0100);
        for (int n = 1; n <= 28; n++) begin
            if (n == 4) begin
                bus.div_wr  = 1'b1;
                bus.div_sel = 2'd2;
                bus.div_val = CNT_W'(6);
            end
            if (n == 5) bus.div_wr = 1'b0;
            #1;
            et = (n == 10 || n == 16 || n == 22 || n == 28)
                 ? 4'b0100 : 4'b0000;
            checks++;
            if (tick !== et)
                $display("FAIL div_update n=%0d: got %b want %b",
                         n, tick, et);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_div_err();
        logic [3:0] et;
        sync_pulse(4'b0100);
        for (int n = 1; n <= 12; n++) begin
            if (n == 1) begin
                bus.div_wr  = 1'b1;
                bus.div_sel = 2'd2;
                bus.div_val = '0;
            end
            if (n == 2) bus.div_wr = 1'b0;
            #1;
            checks++;
            if (bus.div_err !== (n == 2))
                $display("FAIL div_err n=%0d: got %b want %b",
                         n, bus.div_err, (n == 2));
            else passed++;
            et = (n % 6 == 0) ? 4'b0100 : 4'b0000;
            checks++;
            if (tick !== et)
                $display("FAIL err_keep_d n=%0d: got %b want %b",
                         n, tick, et);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_sync();
        logic [3:0] et;
        logic [1:0] es;
        ch_en = 4'b0;
        set_div(0, 5);
        set_div(1, 7);
        sync_pulse(4'b0001);
        for (int n = 1; n <= 5; n++) begin
            if (n == 3) ch_en = 4'b0011;
            if (n == 5) sync = 1'b1;
            #1;
            checks++;
            if (tick !== 4'b0)
                $display("FAIL pre_sync n=%0d: got %b want 0000", n, tick);
            else passed++;
            cyc();
        end
        sync = 1'b0;
        for (int m = 1; m <= 14; m++) begin
            #1;
            et = {2'b00, m % 7 == 0, m % 5 == 0};
            es = {((m - 1) % 7) < 3, ((m - 1) % 5) < 2};
            checks++;
            if (tick !== et)
                $display("FAIL post_sync m=%0d: got %b want %b", m, tick, et);
            else passed++;
            checks++;
            if (sq[1:0] !== es)
                $display("FAIL odd_sq m=%0d: got %b want %b", m, sq[1:0], es);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_div_one();
        ch_en = 4'b0;
        set_div(3, 1);
        sync_pulse(4'b1000);
        for (int n = 1; n <= 6; n++) begin
            ch_en = (n == 4) ? 4'b0000 : 4'b1000;
            #1;
            checks++;
            if (tick[3] !== (n != 4) || sq[3] !== 1'b0)
                $display("FAIL div_one n=%0d: tick=%b sq=%b want %b/0",
                         n, tick[3], sq[3], (n != 4));
            else passed++;
            cyc();
        end
    endtask

    task automatic test_sync_write();
        ch_en       = 4'b0100;
        sync        = 1'b1;
        bus.div_wr  = 1'b1;
        bus.div_sel = 2'd2;
        bus.div_val = CNT_W'(3);
        #1;
        checks++;
        if (tick !== 4'b0)
            $display("FAIL sync_wr_tick: got %b want 0000", tick);
        else passed++;
        cyc();
        sync       = 1'b0;
        bus.div_wr = 1'b0;
        for (int m = 1; m <= 6; m++) begin
            #1;
            checks++;
            if (tick[2] !== (m % 3 == 0))
                $display("FAIL sync_wr m=%0d: got %b want %b",
                         m, tick[2], (m % 3 == 0));
            else passed++;
            cyc();
        end
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        rst         = 1'b1;
        ch_en       = 4'b0;
        casc        = 4'b0;
        sync        = 1'b0;
        bus.div_wr  = 1'b0;
        bus.div_sel = 2'd0;
        bus.div_val = '0;
        cyc();
        test_reset();
        test_cascade();
        test_div_update();
        test_div_err();
        test_sync();
        test_div_one();
        test_sync_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
